// File: rtl/debug_in_port_pkg.sv
// Shared constants and types for the debug input port.
package debug_in_port_pkg;

  // CPU register-file address bus width and the debug register address.
  localparam int REG_ADDR_WIDTH = 4;
  localparam logic [REG_ADDR_WIDTH-1:0] R3 = 4'd3;

  // System default for the serial bit period (clk cycles per bit).
  localparam int DBG_CLKS_PER_BIT = 16;

  // Serial receiver states.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/debug_in_port_uart_rx_byte.sv
// 8N1 serial byte receiver: input synchronizer, framing FSM and shift register.
// byte_valid / frame_err_pulse are asserted during the stop-sample cycle so the
// consumer acts on the same edge at which the stop bit is sampled.
module uart_rx_byte
  import debug_in_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DBG_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err_pulse
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(CLKS_PER_BIT / 2 - 1);

  logic          r_rx_meta;
  logic          r_rx_s;
  rx_state_e     r_state;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          w_stop_sample;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Framing FSM; tick counter restarts on every state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RX_IDLE;
      r_tick    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_tick <= '0;
          if (!r_rx_s) begin
            r_state <= RX_START;
          end else begin
            r_state <= RX_IDLE;
          end
        end
        RX_START: begin
          if (r_tick == TICK_MID) begin
            r_tick    <= '0;
            r_bit_idx <= 3'd0;
            // A start bit that is high again at mid-bit is a glitch.
            r_state   <= r_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_tick == TICK_LAST) begin
            r_tick  <= '0;
            r_state <= r_rx_s ? RX_IDLE : RX_BREAK;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end
        RX_BREAK: begin
          // Held-low line: wait for the idle level before rearming.
          r_tick <= '0;
          if (r_rx_s) begin
            r_state <= RX_IDLE;
          end else begin
            r_state <= RX_BREAK;
          end
        end
        default: begin
          r_state <= RX_IDLE;
          r_tick  <= '0;
        end
      endcase
    end
  end

  assign w_stop_sample   = (r_state == RX_STOP) && (r_tick == TICK_LAST);
  assign byte_valid      = w_stop_sample && r_rx_s;
  assign frame_err_pulse = w_stop_sample && !r_rx_s;
  assign byte_data       = r_shift;

endmodule

// File: rtl/debug_in_port.sv
// Debug input port: serial receiver feeding a small FIFO whose head byte is
// presented to the CPU as register R3; a load from R3 pops the head.
module debug_in_port
  import debug_in_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = DBG_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  input  logic                      ld_ce,
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic                      clear_err,
  output logic [7:0]                debug_reg,
  output logic                      rx_valid,
  output logic                      overflow,
  output logic                      frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  logic          w_byte_valid;
  logic [7:0]    w_byte_data;
  logic          w_frame_err_pulse;
  logic          w_pop;
  logic          w_full;
  logic          w_push_ok;
  logic          w_drop;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .byte_valid     (w_byte_valid),
    .byte_data      (w_byte_data),
    .frame_err_pulse(w_frame_err_pulse)
  );

  assign rx_valid  = (r_count != '0);
  assign w_full    = (r_count == COUNT_FULL);
  assign w_pop     = ld_ce && (addr == R3) && rx_valid;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_byte_valid && (!w_full || w_pop);
  assign w_drop    = w_byte_valid && w_full && !w_pop;

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_byte_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - 1'b1;
      end else begin
        r_count <= r_count;
      end
    end
  end

  // Sticky error flags; a set event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
      if (w_frame_err_pulse) begin
        r_frame_err <= 1'b1;
      end else if (clear_err) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  assign debug_reg = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_debug_in_port.sv
// Directed testbench for debug_in_port at CLKS_PER_BIT = 16, FIFO_DEPTH = 4.
module tb_debug_in_port;
  import debug_in_port_pkg::*;

  localparam int CPB = 16;

  logic                      clk;
  logic                      rst_n;
  logic                      rx;
  logic                      ld_ce;
  logic [REG_ADDR_WIDTH-1:0] addr;
  logic                      clear_err;
  logic [7:0]                debug_reg;
  logic                      rx_valid;
  logic                      overflow;
  logic                      frame_err;

  int n_vec = 0;
  int n_err = 0;

  debug_in_port #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .ld_ce    (ld_ce),
    .addr     (addr),
    .clear_err(clear_err),
    .debug_reg(debug_reg),
    .rx_valid (rx_valid),
    .overflow (overflow),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Drive a frame one bit-period per CPB negedges. Optionally pop or clear at
  // a given cycle (cycle 154 drives the stop-sample edge) and check push latency.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int n_cyc,
                            input int pop_c, input int clr_c, input bit chk_lat,
                            input logic [7:0] pop_head);
    int idx;
    for (int c = 0; c < n_cyc; c++) begin
      @(negedge clk);
      idx = c / CPB;
      if (idx == 0) rx = 1'b0;
      else if (idx <= 8) rx = d[idx-1];
      else rx = stop_b;
      ld_ce     = (c == pop_c);
      addr      = (c == pop_c) ? R3 : 4'd0;
      clear_err = (c == clr_c);
      if (c == pop_c) begin
        #1 check_eq("head_at_stop_pop", debug_reg, pop_head);
      end
      if (chk_lat && c == 153) begin
        @(posedge clk); #1;
        check_eq("valid_before_stop", {7'd0, rx_valid}, 8'd0);
      end
      if (chk_lat && c == 154) begin
        @(posedge clk); #1;
        check_eq("valid_after_stop", {7'd0, rx_valid}, 8'd1);
      end
    end
    @(negedge clk);
    ld_ce     = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    send_frame(d, 1'b1, 10 * CPB, -1, -1, 1'b0, 8'h00);
    idle(4);
  endtask

  task automatic pop(input logic [7:0] exp_head);
    @(negedge clk);
    ld_ce = 1'b1;
    addr  = R3;
    #1 check_eq("pop_head", debug_reg, exp_head);
    @(negedge clk);
    ld_ce = 1'b0;
    addr  = 4'd0;
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; ld_ce = 1'b0; addr = 4'd0; clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_debug_reg", debug_reg, 8'h00);
    check_eq("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    check_eq("rst_overflow", {7'd0, overflow}, 8'd0);
    check_eq("rst_frame_err", {7'd0, frame_err}, 8'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(4);

    // Single byte with push-latency check.
    send_frame(8'hA5, 1'b1, 10 * CPB, -1, -1, 1'b1, 8'h00);
    idle(2);
    check_eq("a5_head", debug_reg, 8'hA5);
    pop(8'hA5);
    check_eq("a5_drained", debug_reg, 8'h00);

    // Three queued bytes, a foreign-address load, then a pop on empty.
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    @(negedge clk); ld_ce = 1'b1; addr = 4'd2;
    @(negedge clk); ld_ce = 1'b0; addr = 4'd0;
    #1 check_eq("other_addr_no_pop", debug_reg, 8'h01);
    pop(8'h01); pop(8'h02); pop(8'h03);
    check_eq("empty_head", debug_reg, 8'h00);
    check_eq("empty_valid", {7'd0, rx_valid}, 8'd0);
    pop(8'h00);
    check_eq("empty_pop_valid", {7'd0, rx_valid}, 8'd0);
    check_eq("empty_pop_ovf", {7'd0, overflow}, 8'd0);

    // Overflow: five bytes into a four-deep FIFO.
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    check_eq("ovf_set", {7'd0, overflow}, 8'd1);
    for (int i = 0; i < 4; i++) pop(8'h10 + 8'(i));
    check_eq("ovf_drained", {7'd0, rx_valid}, 8'd0);
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
    check_eq("ovf_cleared", {7'd0, overflow}, 8'd0);

    // Full FIFO with a pop on the exact stop-sample cycle.
    for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
    send_frame(8'h55, 1'b1, 10 * CPB, 154, -1, 1'b0, 8'h20);
    idle(2);
    check_eq("full_pop_no_ovf", {7'd0, overflow}, 8'd0);
    pop(8'h21); pop(8'h22); pop(8'h23);
    check_eq("full_pop_head55", debug_reg, 8'h55);
    pop(8'h55);

    // Framing error with a coincident clear (set wins), held-low break.
    send_frame(8'h7E, 1'b0, 10 * CPB, -1, 154, 1'b0, 8'h00);
    rx = 1'b0;
    check_eq("ferr_set", {7'd0, frame_err}, 8'd1);
    check_eq("ferr_no_push", {7'd0, rx_valid}, 8'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rx = 1'b0;
      clear_err = (i == 50);
    end
    clear_err = 1'b0;
    check_eq("ferr_cleared", {7'd0, frame_err}, 8'd0);
    idle(20);
    send_byte(8'h3C);
    check_eq("after_break_data", debug_reg, 8'h3C);
    check_eq("single_ferr", {7'd0, frame_err}, 8'd0);
    pop(8'h3C);

    // Start-bit glitch.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle(40);
    check_eq("glitch_no_push", {7'd0, rx_valid}, 8'd0);
    check_eq("glitch_no_err", {7'd0, frame_err}, 8'd0);

    // Reset mid-frame with a byte already buffered.
    send_byte(8'h99);
    send_frame(8'hC3, 1'b1, 60, -1, -1, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_head", debug_reg, 8'h00);
    check_eq("midrst_valid", {7'd0, rx_valid}, 8'd0);
    @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    idle(20);
    check_eq("midrst_no_partial", {7'd0, rx_valid}, 8'd0);
    send_byte(8'hC3);
    check_eq("midrst_c3", debug_reg, 8'hC3);
    check_eq("midrst_no_ferr", {7'd0, frame_err}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
